// File: rtl/frame_scanout.sv
// frame_scanout: read side of the 160x120 frame buffer. Scans stored pixels out to a
// 640x480@60 Hz VGA monitor with 4x pixel replication, generating all VGA timing.
//
// Ports:
//   CLOCK_50     in   50 MHz system clock
//   resetn       in   asynchronous active-low reset
//   fb_addr      out  frame-buffer read address, combinational from the scan counters
//   fb_rdata     in   frame-buffer read data, valid one CLOCK_50 edge after fb_addr
//   VGA_R/G/B    out  colour to the DAC (zero outside the visible region)
//   VGA_HS/VS    out  active-low syncs
//   VGA_BLANK_N  out  low outside the visible region
//   VGA_SYNC_N   out  tied low
//   VGA_CLK      out  25 MHz pixel clock (phase register)
//   frame_done   out  one-CLOCK_50 pulse when the scan wraps from the last pixel to (0,0)
module frame_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_WIDTH    = 160
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  output logic [14:0] fb_addr,
  input  logic [23:0] fb_rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        frame_done
);

  localparam logic [9:0] HLast   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] HsFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        ph_q, ph_d;
  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        done_q, done_d;

  logic        visible;
  logic [14:0] row_base;
  logic [14:0] col;

  assign visible  = (hc_q < HActive) && (vc_q < VActive);
  assign row_base = 15'(vc_q >> SCALE_SHIFT) * 15'(FB_WIDTH);
  assign col      = 15'(hc_q >> SCALE_SHIFT);
  // Clamp off-screen addresses so the RAM never sees an out-of-range read.
  assign fb_addr  = visible ? (row_base + col) : 15'd0;

  always_comb begin
    ph_d      = ~ph_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    done_d    = 1'b0;
    // ph_q high marks a pixel tick; fb_rdata for the current counters has arrived by now.
    if (ph_q) begin
      rgb_d     = visible ? fb_rdata : 24'd0;
      hs_d      = !((hc_q >= HsFirst) && (hc_q <= HsLast));
      vs_d      = !((vc_q >= VsFirst) && (vc_q <= VsLast));
      blank_n_d = visible;
      if (hc_q == HLast) begin
        hc_d = 10'd0;
        if (vc_q == VLast) begin
          vc_d   = 10'd0;
          done_d = 1'b1;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ph_q      <= 1'b0;
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
      rgb_q     <= 24'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      done_q    <= done_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = ph_q;
  assign frame_done  = done_q;

endmodule
